rename_reg_file: RTL and testbench
==================================

// Module: rename_reg_file
// PURPOSE
//  Multi-ported architectural register file with per-register busy bit and ROB tag.
//  Successor to the single-issue status register file, generalised to NDISP dispatch
//  slots, NRD read ports and NWB writeback ports, with same-cycle writeback forwarding.
//  Sits between decode/dispatch (sets busy and tag on rd) and the CDB writeback
//  (writes data, clears busy on tag match); the reservation stations read it.
// PARAMETERS
//  NREG   64  number of registers; index 0 is hardwired to zero
//  XLEN   32  data width
//  TAGW    6  ROB tag width
//  NDISP   2  dispatch (rename) slots per cycle
//  NRD     4  read ports
//  NWB     2  writeback ports
// PORTS (RW = $clog2(NREG))
//  clk         in   1           clock, all state on rising edge
//  reset       in   1           asynchronous, active-high
//  mispred     in   1           synchronous flush of busy and tag state
//  rd_reg      in   NRD*RW      read register index per port
//  rd_data     out  NRD*(XLEN+1) per port {busy, data}
//  rd_tag      out  NRD*TAGW    per port current tag
//  dc_valid    in   NDISP       dispatch slot valid
//  dc_rd       in   NDISP*RW    dispatch destination register
//  dc_tag      in   NDISP*TAGW  ROB entry allocated to that slot
//  wb_valid    in   NWB         writeback valid
//  wb_reg      in   NWB*RW      writeback register
//  wb_tag      in   NWB*TAGW    producing ROB tag
//  wb_data     in   NWB*XLEN    result
// BEHAVIOUR
//  - Reset (async): all busy=0, tags=0, data=0; rd_data={0,0}, rd_tag=0 for every index.
//  - Reads combinational, 0-cycle. Index 0 -> data 0, busy 0, tag 0 always.
//  - Read forwarding: if any wb_valid[w] has wb_reg==rd_reg, rd_reg!=0 and
//    wb_tag==stored tag[rd_reg] -> rd_data={0, wb_data[w]}. Otherwise stored value.
//  - Reads never see this cycle's dispatch (pre-edge busy/tag); intra-group
//    dependencies are resolved by the rename stage.
//  - Writeback, per w: if wb_valid and wb_reg!=0: data<=wb_data; busy<=0 only if
//    wb_tag==tag[wb_reg] (pre-edge tag). Stale-tag writeback updates data, keeps busy.
//  - Dispatch, per slot d with dc_valid and dc_rd!=0: busy<=1, tag<=dc_tag.
//  - Same reg, dispatch and writeback in one cycle: dispatch wins busy/tag; data still written.
//  - Same reg in two dispatch slots: highest slot index wins.
//  - Same reg on two writeback ports: illegal (assertion); highest port index wins.
//  - mispred=1: next edge all busy=0, tags=0; dispatch ignored that cycle;
//    writeback data still written. mispred has priority over dispatch and busy clear.
//  - No stall or back-pressure; every input accepted every cycle.
// STRUCTURE
//  - core_pkg: typedefs reg_idx_t [RW-1:0], rob_tag_t [TAGW-1:0], xdata_t;
//    constant REG_ZERO='0.
//  - Sub-module rrf_read_port (one per read port, generate loop): zero check,
//    writeback tag-match forwarding mux, {busy,data}/tag output.
//  - Top: data/tag/busy arrays, ordered dispatch/writeback update loops, flush, assertions.
// TESTING
//  1 reset mid-run with r5 busy tag 7 -> immediately rd r5 = {0,0}, tag 0, asynchronously.
//  2 dispatch r5 tag 3; next cycle wb r5 tag 3 data 0xDEADBEEF, same-cycle read r5
//    -> {0,0xDEADBEEF}; next cycle stored busy 0.
//  3 dispatch r5 tag 3, then r5 tag 9; wb r5 tag 3 data 0x11 -> data 0x11, busy 1, tag 9.
//  4 slots 0,1 both dc_rd=r8, tags 4,5 -> tag[r8]=5, busy 1; dc_rd=0 -> r0 reads {0,0}.
//  5 r2,r3 busy; mispred with dispatch r4 tag 6 and wb r2 data 0x55 -> r2,r3,r4 busy 0,
//    tags 0, r2 data 0x55.
//  6 same cycle: dispatch r7 tag 2 and wb r7 old tag matching, data 0xAA -> busy 1,
//    tag 2, data 0xAA.

Source files
------------

// File: rtl/rename_reg_file_pkg.sv
// Shared sizes and types for the rename register file.
// Imported by the interface, the read-port sub-module and the top.
package rename_reg_file_pkg;
  localparam int NREG  = 64;
  localparam int XLEN  = 32;
  localparam int TAGW  = 6;
  localparam int NDISP = 2;
  localparam int NRD   = 4;
  localparam int NWB   = 2;
  localparam int RW    = $clog2(NREG);

  typedef logic [RW-1:0]   reg_idx_t;
  typedef logic [TAGW-1:0] rob_tag_t;
  typedef logic [XLEN-1:0] xdata_t;

  localparam reg_idx_t REG_ZERO = '0;
endpackage

// File: rtl/rename_reg_file_if.sv
// Dispatch, writeback, flush and read-port bundle of the rename register file.
// The pipeline drives it through master; the register file uses slave.
interface rename_reg_file_if;
  import rename_reg_file_pkg::*;

  logic                     mispred;
  logic [NRD*RW-1:0]        rd_reg;
  logic [NRD*(XLEN+1)-1:0]  rd_data;
  logic [NRD*TAGW-1:0]      rd_tag;
  logic [NDISP-1:0]         dc_valid;
  logic [NDISP*RW-1:0]      dc_rd;
  logic [NDISP*TAGW-1:0]    dc_tag;
  logic [NWB-1:0]           wb_valid;
  logic [NWB*RW-1:0]        wb_reg;
  logic [NWB*TAGW-1:0]      wb_tag;
  logic [NWB*XLEN-1:0]      wb_data;

  modport master (
    output mispred, rd_reg, dc_valid, dc_rd, dc_tag,
           wb_valid, wb_reg, wb_tag, wb_data,
    input  rd_data, rd_tag
  );

  modport slave (
    input  mispred, rd_reg, dc_valid, dc_rd, dc_tag,
           wb_valid, wb_reg, wb_tag, wb_data,
    output rd_data, rd_tag
  );
endinterface

// File: rtl/rename_reg_file_read_port.sv
// One combinational read port: r0 is forced to zero, and a writeback whose tag
// matches the stored tag is forwarded as a non-busy value in the same cycle.
module rrf_read_port
  import rename_reg_file_pkg::*;
(
  input  reg_idx_t          i_rd_reg,
  input  logic              i_busy,
  input  xdata_t            i_data,
  input  rob_tag_t          i_tag,
  input  logic [NWB-1:0]    i_wb_valid,
  input  logic [NWB*RW-1:0] i_wb_reg,
  input  logic [NWB*TAGW-1:0] i_wb_tag,
  input  logic [NWB*XLEN-1:0] i_wb_data,
  output logic [XLEN:0]     o_data,
  output rob_tag_t          o_tag
);

  logic   w_fwd;
  xdata_t w_fwd_data;

  // Later ports override earlier ones, matching the storage update order.
  always_comb begin
    w_fwd      = 1'b0;
    w_fwd_data = '0;
    for (int w = 0; w < NWB; w++) begin
      if (i_wb_valid[w] &&
          i_wb_reg[w*RW +: RW] == i_rd_reg &&
          i_wb_tag[w*TAGW +: TAGW] == i_tag) begin
        w_fwd      = 1'b1;
        w_fwd_data = i_wb_data[w*XLEN +: XLEN];
      end
    end
  end

  always_comb begin
    o_data = '0;
    o_tag  = '0;
    if (i_rd_reg != REG_ZERO) begin
      o_tag = i_tag;
      if (w_fwd) o_data = {1'b0, w_fwd_data};
      else       o_data = {i_busy, i_data};
    end
  end

endmodule

// File: rtl/rename_reg_file.sv
// Architectural register file with per-register busy bit and ROB tag, updated by
// dispatch (rename) and CDB writeback, and flushed on branch mispredict.
module rename_reg_file
  import rename_reg_file_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  rename_reg_file_if.slave bus
);

  xdata_t           r_data [NREG];
  rob_tag_t         r_tag  [NREG];
  logic [NREG-1:0]  r_busy;

  reg_idx_t w_rd_reg  [NRD];
  reg_idx_t w_dc_rd   [NDISP];
  rob_tag_t w_dc_tag  [NDISP];
  reg_idx_t w_wb_reg  [NWB];
  rob_tag_t w_wb_tag  [NWB];
  xdata_t   w_wb_data [NWB];
  logic [XLEN:0] w_port_data [NRD];
  rob_tag_t      w_port_tag  [NRD];

  always_comb begin
    for (int p = 0; p < NRD; p++) w_rd_reg[p] = bus.rd_reg[p*RW +: RW];
    for (int d = 0; d < NDISP; d++) begin
      w_dc_rd[d]  = bus.dc_rd[d*RW +: RW];
      w_dc_tag[d] = bus.dc_tag[d*TAGW +: TAGW];
    end
    for (int w = 0; w < NWB; w++) begin
      w_wb_reg[w]  = bus.wb_reg[w*RW +: RW];
      w_wb_tag[w]  = bus.wb_tag[w*TAGW +: TAGW];
      w_wb_data[w] = bus.wb_data[w*XLEN +: XLEN];
    end
  end

  // Writeback first, then flush or dispatch, so dispatch wins busy/tag on a
  // shared register while data is still written; higher slot/port indices win.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_busy <= '0;
      for (int i = 0; i < NREG; i++) begin
        r_data[i] <= '0;
        r_tag[i]  <= '0;
      end
    end else begin
      for (int w = 0; w < NWB; w++) begin
        if (bus.wb_valid[w] && w_wb_reg[w] != REG_ZERO) begin
          r_data[w_wb_reg[w]] <= w_wb_data[w];
          if (w_wb_tag[w] == r_tag[w_wb_reg[w]]) r_busy[w_wb_reg[w]] <= 1'b0;
        end
      end
      if (bus.mispred) begin
        r_busy <= '0;
        for (int i = 0; i < NREG; i++) r_tag[i] <= '0;
      end else begin
        for (int d = 0; d < NDISP; d++) begin
          if (bus.dc_valid[d] && w_dc_rd[d] != REG_ZERO) begin
            r_busy[w_dc_rd[d]] <= 1'b1;
            r_tag[w_dc_rd[d]]  <= w_dc_tag[d];
          end
        end
      end
    end
  end

  for (genvar p = 0; p < NRD; p++) begin : g_read
    rrf_read_port u_port (
      .i_rd_reg   (w_rd_reg[p]),
      .i_busy     (r_busy[w_rd_reg[p]]),
      .i_data     (r_data[w_rd_reg[p]]),
      .i_tag      (r_tag[w_rd_reg[p]]),
      .i_wb_valid (bus.wb_valid),
      .i_wb_reg   (bus.wb_reg),
      .i_wb_tag   (bus.wb_tag),
      .i_wb_data  (bus.wb_data),
      .o_data     (w_port_data[p]),
      .o_tag      (w_port_tag[p])
    );
  end

  always_comb begin
    for (int p = 0; p < NRD; p++) begin
      bus.rd_data[p*(XLEN+1) +: XLEN+1] = w_port_data[p];
      bus.rd_tag[p*TAGW +: TAGW]        = w_port_tag[p];
    end
  end

  // Two writeback ports targeting the same non-zero register is a producer bug.
  for (genvar a = 0; a < NWB; a++) begin : g_wb_a
    for (genvar b = a + 1; b < NWB; b++) begin : g_wb_b
      assert property (@(posedge clk) disable iff (reset)
        !(bus.wb_valid[a] && bus.wb_valid[b] &&
          w_wb_reg[a] == w_wb_reg[b] && w_wb_reg[a] != REG_ZERO))
        else $error("rename_reg_file: duplicate writeback register");
    end
  end

endmodule

// File: tb/tb_rename_reg_file.sv
// Directed bench for rename_reg_file: reset, forwarding, stale writeback,
// dispatch ordering, mispredict flush and dispatch/writeback collisions.
module tb_rename_reg_file;
  import rename_reg_file_pkg::*;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  rename_reg_file_if rf ();

  rename_reg_file dut (
    .clk   (clk),
    .reset (reset),
    .bus   (rf.slave)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idleInputs();
    rf.mispred  = 1'b0;
    rf.dc_valid = '0;
    rf.dc_rd    = '0;
    rf.dc_tag   = '0;
    rf.wb_valid = '0;
    rf.wb_reg   = '0;
    rf.wb_tag   = '0;
    rf.wb_data  = '0;
  endtask

  task automatic setDispatch(input int slot, input int rd, input int tag);
    rf.dc_valid[slot]              = 1'b1;
    rf.dc_rd[slot*RW +: RW]        = RW'(rd);
    rf.dc_tag[slot*TAGW +: TAGW]   = TAGW'(tag);
  endtask

  task automatic setWb(input int port, input int rg, input int tag, input logic [31:0] data);
    rf.wb_valid[port]              = 1'b1;
    rf.wb_reg[port*RW +: RW]       = RW'(rg);
    rf.wb_tag[port*TAGW +: TAGW]   = TAGW'(tag);
    rf.wb_data[port*XLEN +: XLEN]  = data;
  endtask

  // Advance one rising edge and return 1 ns after it with inputs idle.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
    idleInputs();
  endtask

  task automatic checkRead(input string tag, input int port, input int rg,
                           input logic expBusy, input logic [31:0] expData, input int expTag);
    logic [XLEN:0] d;
    rf.rd_reg[port*RW +: RW] = RW'(rg);
    #1;
    d = rf.rd_data[port*(XLEN+1) +: XLEN+1];
    checkOutput({tag, ".busy"}, 64'(d[XLEN]), 64'(expBusy));
    checkOutput({tag, ".data"}, 64'(d[XLEN-1:0]), 64'(expData));
    checkOutput({tag, ".tag"}, 64'(rf.rd_tag[port*TAGW +: TAGW]), 64'(expTag));
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    rf.rd_reg = '0;
    idleInputs();
    #3;
    checkRead("rst_r5", 0, 5, 1'b0, 32'h0, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // async reset mid-run
    setDispatch(0, 5, 7);
    applyStimulus();
    checkRead("pre_rst_r5", 0, 5, 1'b1, 32'h0, 7);
    reset = 1'b1;
    #1;
    checkRead("async_rst_r5", 0, 5, 1'b0, 32'h0, 0);
    reset = 1'b0;

    // matching writeback forwarded then stored
    setDispatch(0, 5, 3);
    applyStimulus();
    setWb(0, 5, 3, 32'hDEADBEEF);
    checkRead("fwd_r5", 0, 5, 1'b0, 32'hDEADBEEF, 3);
    applyStimulus();
    checkRead("stored_r5", 0, 5, 1'b0, 32'hDEADBEEF, 3);

    // stale-tag writeback: data updated, busy kept
    setDispatch(0, 5, 3);
    applyStimulus();
    setDispatch(1, 5, 9);
    applyStimulus();
    setWb(0, 5, 3, 32'h11);
    checkRead("stale_nofwd_r5", 1, 5, 1'b1, 32'hDEADBEEF, 9);
    applyStimulus();
    checkRead("stale_r5", 1, 5, 1'b1, 32'h11, 9);

    // same register in both dispatch slots, and r0 ignored
    setDispatch(0, 8, 4);
    setDispatch(1, 8, 5);
    applyStimulus();
    checkRead("dual_disp_r8", 2, 8, 1'b1, 32'h0, 5);
    setDispatch(0, 0, 3);
    setWb(0, 0, 0, 32'h99);
    checkRead("r0_wb_nofwd", 2, 0, 1'b0, 32'h0, 0);
    applyStimulus();
    checkRead("r0_after", 2, 0, 1'b0, 32'h0, 0);

    // mispredict flush
    setDispatch(0, 2, 10);
    setDispatch(1, 3, 11);
    applyStimulus();
    checkRead("pre_flush_r3", 3, 3, 1'b1, 32'h0, 11);
    rf.mispred = 1'b1;
    setDispatch(0, 4, 6);
    setWb(1, 2, 10, 32'h55);
    applyStimulus();
    checkRead("flush_r2", 0, 2, 1'b0, 32'h55, 0);
    checkRead("flush_r3", 1, 3, 1'b0, 32'h0, 0);
    checkRead("flush_r4", 2, 4, 1'b0, 32'h0, 0);
    checkRead("flush_r5", 3, 5, 1'b0, 32'h11, 0);

    // dispatch and matching writeback on the same register
    setDispatch(0, 7, 1);
    applyStimulus();
    setDispatch(1, 7, 2);
    setWb(0, 7, 1, 32'hAA);
    applyStimulus();
    checkRead("disp_wb_r7", 0, 7, 1'b1, 32'hAA, 2);

    // forwarding from writeback port 1 onto read port 3
    setWb(1, 7, 2, 32'hBB);
    checkRead("fwd_port1_r7", 3, 7, 1'b0, 32'hBB, 2);
    applyStimulus();
    checkRead("clear_r7", 3, 7, 1'b0, 32'hBB, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
